// File: rtl/sameclk_mchffctrl.sv
// Multi-channel FIFO pointer controller sharing one RAM, all logic on a single clock.
// Define MCHFF_STICKY_ERR_EN to register wrerr/rderr as sticky flags cleared by errclr.
module sameclk_mchffctrl #(
   parameter int unsigned ADDRB = 4,
   parameter int unsigned CHANB = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifowr,
   input  logic [CHANB-1:0]       wrch,
   input  logic                   fiford,
   input  logic [CHANB-1:0]       rdch,
   input  logic                   fifoflush,
   input  logic [CHANB-1:0]       flushch,
   input  logic [ADDRB:0]         afthres,
   input  logic [CHANB-1:0]       lench,
   input  logic                   errclr,
   output logic [(1<<CHANB)-1:0]  fifofull,
   output logic [(1<<CHANB)-1:0]  afull,
   output logic [(1<<CHANB)-1:0]  fifonemp,
   output logic [ADDRB:0]         fifolen,
   output logic                   write,
   output logic [CHANB+ADDRB-1:0] wraddr,
   output logic                   read,
   output logic [CHANB+ADDRB-1:0] rdaddr,
   output logic                   wrerr,
   output logic                   rderr
);

   localparam int unsigned NCH = 1 << CHANB;
   localparam logic [ADDRB:0] PTR_ONE  = {{ADDRB{1'b0}}, 1'b1};
   localparam logic [ADDRB:0] FULL_LEN = {1'b1, {ADDRB{1'b0}}};

   logic [ADDRB:0] wrpnt [NCH];
   logic [ADDRB:0] rdpnt [NCH];
   logic [ADDRB:0] len   [NCH];
   logic           wr_req, rd_req;
   logic           wr_flushed, rd_flushed;
   logic           wrerr_now, rderr_now;

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         len[c]      = wrpnt[c] - rdpnt[c];
         fifofull[c] = (len[c] == FULL_LEN);
         fifonemp[c] = (len[c] != '0);
         afull[c]    = (len[c] >= afthres);
      end
   end

   assign fifolen = len[lench];

   // Requests are masked during reset so no strobe or error escapes while pointers are held.
   assign wr_req     = fifowr & ~rst;
   assign rd_req     = fiford & ~rst;
   assign wr_flushed = fifoflush && (flushch == wrch);
   assign rd_flushed = fifoflush && (flushch == rdch);

   assign write  = wr_req & ~fifofull[wrch] & ~wr_flushed;
   assign read   = rd_req & fifonemp[rdch] & ~rd_flushed;
   assign wraddr = {wrch, wrpnt[wrch][ADDRB-1:0]};
   assign rdaddr = {rdch, rdpnt[rdch][ADDRB-1:0]};

   assign wrerr_now = wr_req & ~write;
   assign rderr_now = rd_req & ~read;

   // Flush is assigned last so it overrides any same-cycle pointer advance on that channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            wrpnt[c] <= '0;
            rdpnt[c] <= '0;
         end
      end else begin
         if (write) wrpnt[wrch] <= wrpnt[wrch] + PTR_ONE;
         if (read)  rdpnt[rdch] <= rdpnt[rdch] + PTR_ONE;
         if (fifoflush) begin
            wrpnt[flushch] <= '0;
            rdpnt[flushch] <= '0;
         end
      end
   end

`ifdef MCHFF_STICKY_ERR_EN
   logic wrerr_q, rderr_q;

   // A fresh error wins over errclr in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrerr_q <= 1'b0;
         rderr_q <= 1'b0;
      end else begin
         if (wrerr_now)   wrerr_q <= 1'b1;
         else if (errclr) wrerr_q <= 1'b0;
         if (rderr_now)   rderr_q <= 1'b1;
         else if (errclr) rderr_q <= 1'b0;
      end
   end

   assign wrerr = wrerr_q;
   assign rderr = rderr_q;
`else
   logic unused_errclr;
   assign unused_errclr = errclr;
   assign wrerr = wrerr_now;
   assign rderr = rderr_now;
`endif

endmodule

// File: tb/tb_sameclk_mchffctrl.sv
// Directed self-checking bench for sameclk_mchffctrl with ADDRB=2, CHANB=2, afthres=3.
// Sticky-error checks are compiled in when MCHFF_STICKY_ERR_EN is defined.
module tb_sameclk_mchffctrl;

   logic       clk, rst;
   logic       fifowr, fiford, fifoflush, errclr;
   logic [1:0] wrch, rdch, flushch, lench;
   logic [2:0] afthres;
   logic [3:0] fifofull, afull, fifonemp;
   logic [2:0] fifolen;
   logic       write, read, wrerr, rderr;
   logic [3:0] wraddr, rdaddr;

   int errors = 0;
   int checks = 0;

   sameclk_mchffctrl #(.ADDRB(2), .CHANB(2)) dut (
      .clk(clk), .rst(rst), .fifowr(fifowr), .wrch(wrch), .fiford(fiford), .rdch(rdch),
      .fifoflush(fifoflush), .flushch(flushch), .afthres(afthres), .lench(lench),
      .errclr(errclr), .fifofull(fifofull), .afull(afull), .fifonemp(fifonemp),
      .fifolen(fifolen), .write(write), .wraddr(wraddr), .read(read), .rdaddr(rdaddr),
      .wrerr(wrerr), .rderr(rderr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fifowr = 0; fiford = 0; fifoflush = 0; errclr = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle(); wrch = 0; rdch = 0; flushch = 0; lench = 0; afthres = 3;
      fifowr = 1; fiford = 1;
      #1;
      checks++; if (fifofull !== 4'b0000) begin errors++; $display("FAIL rst_full: got %b want 0000", fifofull); end
      checks++; if (fifonemp !== 4'b0000) begin errors++; $display("FAIL rst_nemp: got %b want 0000", fifonemp); end
      checks++; if (fifolen !== 3'd0) begin errors++; $display("FAIL rst_len: got %0d want 0", fifolen); end
      checks++; if (afull !== 4'b0000) begin errors++; $display("FAIL rst_afull: got %b want 0000", afull); end
      checks++; if ({write, read, wrerr, rderr} !== 4'b0000) begin
         errors++; $display("FAIL rst_strobes: got %b want 0000", {write, read, wrerr, rderr}); end
      afthres = 0;
      #1;
      checks++; if (afull !== 4'b1111) begin errors++; $display("FAIL rst_afull_thr0: got %b want 1111", afull); end
      afthres = 3; idle();
      tick();
      rst = 0;
      #1;
      checks++; if (fifonemp !== 4'b0000) begin errors++; $display("FAIL post_rst_nemp: got %b want 0000", fifonemp); end
   endtask

   task automatic test_fill();
      logic [3:0] exp_af;
      lench = 1;
      for (int i = 0; i < 4; i++) begin
         fifowr = 1; wrch = 1;
         #1;
         checks++; if (write !== 1'b1) begin errors++; $display("FAIL fill_write%0d: got %b want 1", i, write); end
         checks++; if (wraddr !== 4'(4 + i)) begin
            errors++; $display("FAIL fill_wraddr%0d: got %0d want %0d", i, wraddr, 4 + i); end
         tick();
         exp_af = (i >= 2) ? 4'b0010 : 4'b0000;
         checks++; if (afull !== exp_af) begin errors++; $display("FAIL fill_afull%0d: got %b want %b", i, afull, exp_af); end
      end
      idle();
      checks++; if (fifofull !== 4'b0010) begin errors++; $display("FAIL fill_full: got %b want 0010", fifofull); end
      checks++; if (fifolen !== 3'd4) begin errors++; $display("FAIL fill_len: got %0d want 4", fifolen); end
   endtask

   task automatic test_full_reject();
      fifowr = 1; wrch = 1; fiford = 1; rdch = 1; lench = 1;
      #1;
      checks++; if (write !== 1'b0) begin errors++; $display("FAIL full_write: got %b want 0", write); end
      checks++; if (read !== 1'b1) begin errors++; $display("FAIL full_read: got %b want 1", read); end
      checks++; if (rdaddr !== 4'd4) begin errors++; $display("FAIL full_rdaddr: got %0d want 4", rdaddr); end
`ifndef MCHFF_STICKY_ERR_EN
      checks++; if (wrerr !== 1'b1) begin errors++; $display("FAIL full_wrerr: got %b want 1", wrerr); end
`endif
      tick(); idle();
      #1;
      checks++; if (fifolen !== 3'd3) begin errors++; $display("FAIL full_len: got %0d want 3", fifolen); end
      checks++; if (fifofull !== 4'b0000) begin errors++; $display("FAIL full_after: got %b want 0000", fifofull); end
`ifndef MCHFF_STICKY_ERR_EN
      checks++; if (wrerr !== 1'b0) begin errors++; $display("FAIL full_wrerr_drop: got %b want 0", wrerr); end
`else
      checks++; if (wrerr !== 1'b1) begin errors++; $display("FAIL full_wrerr_sticky: got %b want 1", wrerr); end
`endif
   endtask

   task automatic test_back_to_back();
      fifowr = 1; wrch = 2; lench = 2;
      #1;
      checks++; if (wraddr !== 4'd8) begin errors++; $display("FAIL prime_wraddr: got %0d want 8", wraddr); end
      tick();
      for (int i = 0; i < 6; i++) begin
         fifowr = 1; wrch = 2; fiford = 1; rdch = 2;
         #1;
         checks++; if ({write, read} !== 2'b11) begin
            errors++; $display("FAIL b2b_strobes%0d: got %b want 11", i, {write, read}); end
         checks++; if (wraddr !== 4'(8 + (i + 1) % 4)) begin
            errors++; $display("FAIL b2b_wraddr%0d: got %0d want %0d", i, wraddr, 8 + (i + 1) % 4); end
         checks++; if (rdaddr !== 4'(8 + i % 4)) begin
            errors++; $display("FAIL b2b_rdaddr%0d: got %0d want %0d", i, rdaddr, 8 + i % 4); end
         tick();
         checks++; if (fifolen !== 3'd1 || fifonemp[2] !== 1'b1) begin
            errors++; $display("FAIL b2b_len%0d: got len %0d nemp %b want len 1 nemp 1", i, fifolen, fifonemp[2]); end
      end
      idle();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         fifowr = 1; wrch = 0;
         tick();
      end
      fifowr = 1; wrch = 0; fifoflush = 1; flushch = 0; lench = 0;
      #1;
      checks++; if (fifolen !== 3'd3) begin errors++; $display("FAIL flush_pre_len: got %0d want 3", fifolen); end
      checks++; if (write !== 1'b0) begin errors++; $display("FAIL flush_write: got %b want 0", write); end
`ifndef MCHFF_STICKY_ERR_EN
      checks++; if (wrerr !== 1'b1) begin errors++; $display("FAIL flush_wrerr: got %b want 1", wrerr); end
`endif
      tick(); idle();
      #1;
      checks++; if (fifolen !== 3'd0) begin errors++; $display("FAIL flush_len0: got %0d want 0", fifolen); end
      lench = 1;
      #1;
      checks++; if (fifolen !== 3'd3) begin errors++; $display("FAIL flush_ch1_kept: got %0d want 3", fifolen); end
      fifowr = 1; wrch = 0;
      tick();
      fifowr = 1; wrch = 3; fifoflush = 1; flushch = 0;
      #1;
      checks++; if (write !== 1'b1 || wraddr !== 4'd12) begin
         errors++; $display("FAIL flush_ch3_write: got %b/%0d want 1/12", write, wraddr); end
      tick(); idle();
      lench = 0;
      #1;
      checks++; if (fifolen !== 3'd0) begin errors++; $display("FAIL flush_len0b: got %0d want 0", fifolen); end
      lench = 3;
      #1;
      checks++; if (fifolen !== 3'd1) begin errors++; $display("FAIL flush_ch3_len: got %0d want 1", fifolen); end
   endtask

   task automatic test_empty_read();
      fifoflush = 1; flushch = 3;
      tick(); idle();
      checks++; if (fifonemp !== 4'b0110) begin errors++; $display("FAIL empty_pre_nemp: got %b want 0110", fifonemp); end
      fiford = 1; rdch = 3; fifowr = 1; wrch = 3; lench = 3;
      #1;
      checks++; if ({read, write} !== 2'b01) begin
         errors++; $display("FAIL empty_strobes: got %b want 01", {read, write}); end
`ifndef MCHFF_STICKY_ERR_EN
      checks++; if (rderr !== 1'b1) begin errors++; $display("FAIL empty_rderr: got %b want 1", rderr); end
`endif
      tick(); idle();
      checks++; if (fifonemp !== 4'b1110) begin errors++; $display("FAIL empty_post_nemp: got %b want 1110", fifonemp); end
      checks++; if (fifolen !== 3'd1) begin errors++; $display("FAIL empty_post_len: got %0d want 1", fifolen); end
`ifdef MCHFF_STICKY_ERR_EN
      for (int i = 0; i < 5; i++) begin
         checks++; if (rderr !== 1'b1) begin errors++; $display("FAIL sticky_hold%0d: got %b want 1", i, rderr); end
         tick();
      end
      errclr = 1;
      #1;
      checks++; if (rderr !== 1'b1) begin errors++; $display("FAIL sticky_preclr: got %b want 1", rderr); end
      tick(); idle();
      checks++; if (rderr !== 1'b0) begin errors++; $display("FAIL sticky_clr: got %b want 0", rderr); end
`else
      checks++; if (rderr !== 1'b0) begin errors++; $display("FAIL empty_rderr_drop: got %b want 0", rderr); end
`endif
   endtask

   task automatic test_async_reset();
      lench = 1;
      #2;
      rst = 1;
      #1;
      checks++; if (fifonemp !== 4'b0000 || fifofull !== 4'b0000) begin
         errors++; $display("FAIL arst_flags: got nemp %b full %b want 0000 0000", fifonemp, fifofull); end
      checks++; if (fifolen !== 3'd0 || afull !== 4'b0000) begin
         errors++; $display("FAIL arst_len: got len %0d afull %b want 0 0000", fifolen, afull); end
      checks++; if ({wrerr, rderr} !== 2'b00) begin
         errors++; $display("FAIL arst_err: got %b want 00", {wrerr, rderr}); end
      tick();
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_reject();
      test_back_to_back();
      test_flush();
      test_empty_read();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
